// File: rtl/node_iter.sv
// Iteration node: applies the child operation COUNT times, RES = f^COUNT(IN).
// Define NODE_ITER_TIMEOUT_EN to add a per-wait-phase watchdog and the ERR port.
module node_iter #(
    parameter int W       = 16,
    parameter int CW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ST,
    input  logic [W-1:0]  IN,
    input  logic [CW-1:0] COUNT,
    output logic          RD,
    output logic [W-1:0]  RES,
    output logic          C_ST,
    output logic [W-1:0]  C_IN,
    input  logic          C_RD,
    input  logic [W-1:0]  C_RES
`ifdef NODE_ITER_TIMEOUT_EN
    ,
    output logic          ERR
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t        state, state_n;
    logic          st_prev;
    logic [W-1:0]  acc, acc_n;
    logic [CW-1:0] rem, rem_n;
    logic          rd_n, cst_n;
    logic [W-1:0]  res_n;
    logic          start;

    assign start = ST & ~st_prev;
    assign C_IN  = acc;

`ifdef NODE_ITER_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt, cnt_n;
    logic            err_n;
    logic            expired;

    // Counter value is 0 on the first cycle of a phase, so the phase lasts TIMEOUT cycles.
    assign expired = (cnt == CNTW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_n = state;
        acc_n   = acc;
        rem_n   = rem;
        rd_n    = RD;
        res_n   = RES;
        cst_n   = C_ST;
`ifdef NODE_ITER_TIMEOUT_EN
        cnt_n   = cnt + 1'b1;
        err_n   = ERR;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    rd_n  = 1'b0;
                    acc_n = IN;
                    rem_n = COUNT;
`ifdef NODE_ITER_TIMEOUT_EN
                    err_n = 1'b0;
                    cnt_n = '0;
`endif
                    if (COUNT == '0) begin
                        state_n = FIN;
                    end else begin
                        cst_n   = 1'b1;
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (!C_RD) begin
                    cst_n   = 1'b0;
                    state_n = WAIT;
`ifdef NODE_ITER_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
`ifdef NODE_ITER_TIMEOUT_EN
                else if (expired) begin
                    cst_n   = 1'b0;
                    err_n   = 1'b1;
                    res_n   = acc;
                    rd_n    = 1'b1;
                    state_n = IDLE;
                end
`endif
            end
            WAIT: begin
                if (C_RD) begin
                    acc_n = C_RES;
                    rem_n = rem - 1'b1;
                    if (rem == CW'(1)) begin
                        res_n   = C_RES;
                        rd_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cst_n   = 1'b1;
                        state_n = REQ;
`ifdef NODE_ITER_TIMEOUT_EN
                        cnt_n   = '0;
`endif
                    end
                end
`ifdef NODE_ITER_TIMEOUT_EN
                else if (expired) begin
                    cst_n   = 1'b0;
                    err_n   = 1'b1;
                    res_n   = acc;
                    rd_n    = 1'b1;
                    state_n = IDLE;
                end
`endif
            end
            FIN: begin
                res_n   = acc;
                rd_n    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            st_prev <= 1'b0;
            acc     <= '0;
            rem     <= '0;
            RD      <= 1'b1;
            RES     <= '0;
            C_ST    <= 1'b0;
`ifdef NODE_ITER_TIMEOUT_EN
            cnt     <= '0;
            ERR     <= 1'b0;
`endif
        end else begin
            // Edge detector tracks ST every cycle, busy or not.
            st_prev <= ST;
            state   <= state_n;
            acc     <= acc_n;
            rem     <= rem_n;
            RD      <= rd_n;
            RES     <= res_n;
            C_ST    <= cst_n;
`ifdef NODE_ITER_TIMEOUT_EN
            cnt     <= cnt_n;
            ERR     <= err_n;
`endif
        end
    end

endmodule

// File: doc/node_iter.md
# node_iter

Iteration node for the computation tree. It applies a child node's operation to its own output COUNT times, so RES = f^COUNT(IN). Upstream, it presents the same ST/RD/RES/IN handshake as every tree node. Downstream, it is the initiator of that handshake toward a single child node: it drives C_ST and C_IN, and consumes C_RD and C_RES.

## Interface
Parameters:
- W, 16, data width of IN, RES, C_IN, C_RES
- CW, 8, width of COUNT (unsigned iteration count)
- TIMEOUT, 64, watchdog limit in cycles per child wait phase (used only with NODE_ITER_TIMEOUT_EN)

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- ST  in  1  upstream start; only a rising edge (ST=1, previous ST=0) starts an operation
- IN  in  W  initial operand, sampled on the start edge
- COUNT  in  CW  iteration count, sampled on the start edge
- RD  out  1  ready; 1 = idle with RES valid, 0 = busy
- RES  out  W  result register
- C_ST  out  1  start strobe to child
- C_IN  out  W  child operand, equal to the internal accumulator ACC
- C_RD  in  1  child ready
- C_RES  in  W  child result
- ERR  out  1  timeout flag; port present only with NODE_ITER_TIMEOUT_EN

## Operation
- Reset values: RD=1, RES=0, C_ST=0, ACC=0, REM=0, state IDLE, previous-ST register=0, ERR=0.
- States:
  - IDLE, REQ, WAIT, FIN.
- IDLE:
  - On a start edge: RD<=0, ACC<=IN, REM<=COUNT.
  - If COUNT==0, go to FIN. Otherwise C_ST<=1 and go to REQ.
- REQ:
  - Hold C_ST=1 until C_RD is sampled 0 (child acknowledge).
  - Then C_ST<=0 and go to WAIT.
- WAIT:
  - Wait until C_RD is sampled 1.
  - Then ACC<=C_RES and REM<=REM-1.
  - If REM==1: RES<=C_RES, RD<=1, go to IDLE.
  - Otherwise: C_ST<=1, go to REQ.
- FIN (COUNT==0 only): RES<=ACC, RD<=1, go to IDLE.
- C_IN=ACC is stable from C_ST rise until C_RD returns to 1.
- Arithmetic:
  - REM is unsigned CW bits.
  - RES/ACC take C_RES verbatim; any wrap-around is the child's.
- Start edges while RD=0 are ignored. The edge detector keeps tracking ST every cycle, so a level held high does not retrigger.
- RST mid-operation: return to reset values on that edge. C_ST drops immediately; the child shares RST.

## Timing
- The start edge is detected at edge E0, and RD=0 is visible after E0.
- COUNT=0: RES=IN and RD=1 after E1. C_ST is never asserted.
- With a child that drops RD on the edge after seeing ST and raises RD two edges later:
  - Each iteration takes 4 cycles: C_ST rises after E0, C_RD=0 at E1, C_ST falls at E2, C_RD=1 at E3, sampled at E4.
  - Total latency is 4·COUNT cycles.
- C_ST is low for at least 2 cycles between iterations, so the child's edge detector always sees a fresh rising edge.
- RES changes only on the edge where RD rises.

## Configuration
- NODE_ITER_TIMEOUT_EN defined:
  - A cycle counter runs in REQ and in WAIT, and clears on each state entry.
  - If it reaches TIMEOUT, the block sets C_ST<=0, ERR<=1, RES<=ACC, RD<=1 and goes to IDLE.
  - ERR clears on the next accepted start edge or on RST.
- NODE_ITER_TIMEOUT_EN undefined:
  - There is no counter and no ERR port.
  - The block waits on C_RD indefinitely.

## Test plan
- Child = increment node. IN=5, COUNT=3, single ST pulse -> RD low 12 cycles, then RES=8, RD=1, exactly 3 C_ST rising edges.
- IN=0x1234, COUNT=0 -> RES=0x1234, RD=1 after E1, C_ST stays 0 throughout.
- IN=0xFFFE, COUNT=3 with the increment child -> RES=0x0001 (wrap passes through).
- ST toggled 0→1→0→1 during a COUNT=4 operation -> ignored. Final RES=IN+4, and only 4 child transactions occur.
- RST asserted while in WAIT during iteration 2 -> next edge RD=1, RES=0, C_ST=0. A following start with IN=0, COUNT=1 -> RES=1.
- NODE_ITER_TIMEOUT_EN, TIMEOUT=16, C_RD stuck at 1 -> after 16 cycles in REQ: ERR=1, RD=1, RES=IN, C_ST=0. The next start with a healthy child clears ERR.
